// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
package imm_pkg;

  typedef enum logic [3:0] {
    FMT_NONE = 4'd0,
    FMT_I    = 4'd1,
    FMT_S    = 4'd2,
    FMT_B    = 4'd3,
    FMT_U    = 4'd4,
    FMT_J    = 4'd5,
    FMT_CI   = 4'd6,
    FMT_CSS  = 4'd7,
    FMT_CIW  = 4'd8,
    FMT_CL   = 4'd9,
    FMT_CS   = 4'd10,
    FMT_CB   = 4'd11,
    FMT_CJ   = 4'd12
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Replicates bit msb of value into every bit above it.
  function automatic logic [63:0] sext(input logic [63:0] value, input int msb);
    logic [63:0] r;
    r = value;
    for (int i = 0; i < 64; i++) begin
      if (i > msb) r[i] = value[msb];
    end
    return r;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Input/output handshake bundle of imm_gen_pipe; master drives instructions, slave is the generator.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_imm;
  imm_pkg::imm_fmt_e    out_fmt;
  logic [TAG_W-1:0]     out_tag;
  logic                 out_illegal;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational instruction -> immediate/format/illegal decoder.
// Compressed (RVC) decode is built only when IMM_GEN_RVC_EN is defined.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  logic is_shift;

  function automatic logic [XLEN-1:0] ext(input logic [63:0] v, input int msb);
    return XLEN'(sext(v, msb));
  endfunction

  assign is_shift = (instr[14:12] == 3'b001) || (instr[14:12] == 3'b101);

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OPC_OP_IMM: begin
          fmt = FMT_I;
          if (is_shift)
            imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
          else
            imm = ext(64'(instr[31:20]), 11);
        end
        OPC_LOAD, OPC_JALR: begin
          fmt = FMT_I;
          imm = ext(64'(instr[31:20]), 11);
        end
        OPC_OP_IMM32: begin
          if (XLEN == 64) begin
            fmt = FMT_I;
            imm = is_shift ? XLEN'(instr[24:20]) : ext(64'(instr[31:20]), 11);
          end else begin
            illegal = 1'b1;
          end
        end
        OPC_SYSTEM: begin
          fmt = FMT_I;
          imm = XLEN'(instr[31:20]);
        end
        OPC_STORE: begin
          fmt = FMT_S;
          imm = ext(64'({instr[31:25], instr[11:7]}), 11);
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          imm = ext(64'({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), 12);
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          imm = ext(64'({instr[31:12], 12'b0}), 31);
        end
        OPC_JAL: begin
          fmt = FMT_J;
          imm = ext(64'({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}), 20);
        end
        default: ;
      endcase
    end else begin
`ifdef IMM_GEN_RVC_EN
      if (instr[15:0] == 16'h0000) begin
        illegal = 1'b1;
      end else begin
        // selector is {quadrant, funct3}
        case ({instr[1:0], instr[15:13]})
          5'b00_000: begin
            fmt = FMT_CIW;
            imm = XLEN'({instr[10:7], instr[12:11], instr[5], instr[6], 2'b00});
          end
          5'b00_010: begin
            fmt = FMT_CL;
            imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
          end
          5'b00_110: begin
            fmt = FMT_CS;
            imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
          end
          5'b01_000, 5'b01_010: begin
            fmt = FMT_CI;
            imm = ext(64'({instr[12], instr[6:2]}), 5);
          end
          5'b01_011: begin
            // rd == x2 is C.ADDI16SP, not decoded here
            if (instr[11:7] != 5'd2) begin
              fmt = FMT_CI;
              imm = ext(64'({instr[12], instr[6:2], 12'b0}), 17);
            end
          end
          5'b01_101: begin
            fmt = FMT_CJ;
            imm = ext(64'({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                           instr[2], instr[11], instr[5:3], 1'b0}), 11);
          end
          5'b01_110, 5'b01_111: begin
            fmt = FMT_CB;
            imm = ext(64'({instr[12], instr[6:5], instr[2], instr[11:10],
                           instr[4:3], 1'b0}), 8);
          end
          5'b10_010: begin
            fmt = FMT_CI;
            imm = XLEN'({instr[3:2], instr[12], instr[6:4], 2'b00});
          end
          5'b10_110: begin
            fmt = FMT_CSS;
            imm = XLEN'({instr[8:7], instr[12:9], 2'b00});
          end
          default: ;
        endcase
      end
`else
      illegal = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decoder, output register and one-entry skid with registered in_ready.
// Optional compressed decode enabled by IMM_GEN_RVC_EN.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  imm_gen_pipe_if.slave bus
);
  // state    | meaning
  // ST_EMPTY | output register empty, skid empty
  // ST_ONE   | output register valid, skid empty
  // ST_TWO   | output register valid and stalled, skid holds the next beat

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  occ_e             state, state_nxt;
  logic             ready_q;
  logic             accept;
  logic             load_out_in, load_out_skid, load_skid;

  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;
  logic             dec_ill;

  logic [XLEN-1:0]  out_imm_q, skid_imm_q;
  imm_fmt_e         out_fmt_q, skid_fmt_q;
  logic [TAG_W-1:0] out_tag_q, skid_tag_q;
  logic             out_ill_q, skid_ill_q;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr   (bus.in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign accept = bus.in_valid && ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != ST_TWO);
    end
  end

  always_comb begin
    state_nxt     = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          load_out_in = 1'b1;
          state_nxt   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && bus.out_ready) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = ST_TWO;
        end else if (bus.out_ready) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so the skid always drains before new input
        if (bus.out_ready) begin
          load_out_skid = 1'b1;
          state_nxt     = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm_q <= '0;
      out_fmt_q <= FMT_NONE;
      out_tag_q <= '0;
      out_ill_q <= 1'b0;
    end else if (load_out_in) begin
      out_imm_q <= dec_imm;
      out_fmt_q <= dec_fmt;
      out_tag_q <= bus.in_tag;
      out_ill_q <= dec_ill;
    end else if (load_out_skid) begin
      out_imm_q <= skid_imm_q;
      out_fmt_q <= skid_fmt_q;
      out_tag_q <= skid_tag_q;
      out_ill_q <= skid_ill_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_imm_q <= '0;
      skid_fmt_q <= FMT_NONE;
      skid_tag_q <= '0;
      skid_ill_q <= 1'b0;
    end else if (load_skid) begin
      skid_imm_q <= dec_imm;
      skid_fmt_q <= dec_fmt;
      skid_tag_q <= bus.in_tag;
      skid_ill_q <= dec_ill;
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = (state != ST_EMPTY);
  assign bus.out_imm     = out_imm_q;
  assign bus.out_fmt     = out_fmt_q;
  assign bus.out_tag     = out_tag_q;
  assign bus.out_illegal = out_ill_q;

endmodule
